gaussian_upsample_reader: RTL

- Read-side consumer of the Gaussian stage output FIFO (empty / rd_en / valid / dout). Feeds the up-sampling path.
- Strips the per-row zero pad words that the Gaussian write side inserts.
- Performs 2x nearest-neighbour up-sampling: each pixel is emitted twice per line, and each line is emitted twice (second copy replayed from an internal line buffer).
- Presents a ready/valid pixel stream with start-of-frame and end-of-line markers.

---
 rtl/gaussian_upsample_reader.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/gaussian_upsample_reader.sv
// gaussian_upsample_reader
//   Read-side consumer of the Gaussian stage output FIFO. Strips the per-row pad
//   words and performs 2x nearest-neighbour up-sampling: every pixel is emitted
//   twice, and every line is emitted twice (the second copy is replayed from an
//   internal line buffer). Output is a ready/valid stream with SOF/EOL markers.
//
// Optional feature: define PAD_CHECK_EN to flag nonzero pad words on pad_err
// (sticky until reset). Without it pad_err is tied low.
//
// Ports:
//   clk, rst          clock; asynchronous active-low reset
//   fifo_empty        Gaussian FIFO empty
//   fifo_rd_en        FIFO read strobe (single-cycle pulse)
//   fifo_valid        read data valid, one cycle after fifo_rd_en
//   fifo_dout         read data
//   out_valid/ready   output handshake
//   out_data          output pixel
//   out_sof           first pixel of an output frame
//   out_eol           last pixel of each output line (2*ROW_W pixels)
//   pad_err           sticky nonzero-pad flag

module gaussian_upsample_reader #(
  parameter int unsigned ROW_W = 399,
  parameter int unsigned PAD_W = 1,
  parameter int unsigned ROWS  = 240,
  parameter int unsigned DW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          fifo_empty,
  output logic          fifo_rd_en,
  input  logic          fifo_valid,
  input  logic [DW-1:0] fifo_dout,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic          out_sof,
  output logic          out_eol,
  input  logic          out_ready,
  output logic          pad_err
);

  localparam int unsigned CW = (ROW_W > 1) ? $clog2(ROW_W) : 1;
  localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned PW = (PAD_W > 1) ? $clog2(PAD_W) : 1;

  localparam logic [CW-1:0] ColLast = CW'(ROW_W - 1);
  localparam logic [RW-1:0] RowLast = RW'(ROWS - 1);
  localparam logic [PW-1:0] PadLast = PW'(PAD_W - 1);

  typedef enum logic [1:0] {StIdle, StFill, StPad, StReplay} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   col_q, col_d;
  logic [RW-1:0]   row_q, row_d;
  logic [PW-1:0]   pad_cnt_q, pad_cnt_d;
  logic            pend_q, pend_d;
  logic            hph_q, hph_d;
  logic            out_valid_q, out_valid_d;
  logic [DW-1:0]   out_data_q, out_data_d;
  logic            out_sof_q, out_sof_d;
  logic            out_eol_q, out_eol_d;

  logic [DW-1:0]   line_buf [ROW_W];
  logic [DW-1:0]   buf_rd_q;
  logic [CW-1:0]   buf_addr;
  logic [CW:0]     buf_sum;
  logic            buf_we;
  logic            captured;
  logic            xfer;

  assign captured = pend_q & fifo_valid;
  assign xfer     = out_valid_q & out_ready;

  // Prefetch address: while the second copy of col is on the output, fetch
  // col+1 so replay can continue back-to-back at one pixel per cycle.
  always_comb begin
    buf_sum  = {1'b0, col_d} + (CW + 1)'(hph_d);
    buf_addr = (buf_sum >= (CW + 1)'(ROW_W)) ? '0 : buf_sum[CW-1:0];
  end

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    pad_cnt_d   = pad_cnt_q;
    hph_d       = hph_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sof_d   = out_sof_q;
    out_eol_d   = out_eol_q;
    buf_we      = 1'b0;

    // Combinational so that it is gated by the current fifo_empty; the hold
    // register must be empty and no read may be pending.
    fifo_rd_en = ((state_q == StFill) || (state_q == StPad)) && !fifo_empty &&
                 !pend_q && !out_valid_q;
    // A pending read without fifo_valid simply lapses and is re-issued.
    pend_d = fifo_rd_en;

    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) state_d = StFill;
      end
      StFill: begin
        if (captured) begin
          buf_we      = 1'b1;
          out_valid_d = 1'b1;
          out_data_d  = fifo_dout;
          out_sof_d   = (row_q == '0) && (col_q == '0);
          out_eol_d   = 1'b0;
          hph_d       = 1'b0;
        end else if (xfer) begin
          if (!hph_q) begin
            hph_d     = 1'b1;
            out_sof_d = 1'b0;
            out_eol_d = (col_q == ColLast);
          end else begin
            out_valid_d = 1'b0;
            out_eol_d   = 1'b0;
            hph_d       = 1'b0;
            if (col_q == ColLast) begin
              col_d   = '0;
              state_d = StPad;
            end else begin
              col_d = col_q + 1'b1;
            end
          end
        end
      end
      StPad: begin
        if (captured) begin
          if (pad_cnt_q == PadLast) begin
            pad_cnt_d = '0;
            state_d   = StReplay;
          end else begin
            pad_cnt_d = pad_cnt_q + 1'b1;
          end
        end
      end
      StReplay: begin
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          out_data_d  = buf_rd_q;
          out_sof_d   = 1'b0;
          out_eol_d   = 1'b0;
          hph_d       = 1'b0;
        end else if (xfer) begin
          if (!hph_q) begin
            hph_d     = 1'b1;
            out_eol_d = (col_q == ColLast);
          end else if (col_q == ColLast) begin
            out_valid_d = 1'b0;
            out_eol_d   = 1'b0;
            hph_d       = 1'b0;
            col_d       = '0;
            if (row_q == RowLast) begin
              row_d   = '0;
              state_d = StIdle;
            end else begin
              row_d   = row_q + 1'b1;
              state_d = StFill;
            end
          end else begin
            col_d      = col_q + 1'b1;
            hph_d      = 1'b0;
            out_data_d = buf_rd_q;
            out_eol_d  = 1'b0;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      col_q       <= '0;
      row_q       <= '0;
      pad_cnt_q   <= '0;
      pend_q      <= 1'b0;
      hph_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sof_q   <= 1'b0;
      out_eol_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      pad_cnt_q   <= pad_cnt_d;
      pend_q      <= pend_d;
      hph_q       <= hph_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sof_q   <= out_sof_d;
      out_eol_q   <= out_eol_d;
    end
  end

  // Line buffer is never read before the current row has been written into
  // it, so it needs no reset.
  always_ff @(posedge clk) begin
    if (buf_we) line_buf[col_q] <= fifo_dout;
    buf_rd_q <= line_buf[buf_addr];
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sof   = out_sof_q;
  assign out_eol   = out_eol_q;

`ifdef PAD_CHECK_EN
  logic pad_err_q, pad_err_d;

  always_comb begin
    pad_err_d = pad_err_q | ((state_q == StPad) && captured && (fifo_dout != '0));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pad_err_q <= 1'b0;
    else      pad_err_q <= pad_err_d;
  end

  assign pad_err = pad_err_q;
`else
  assign pad_err = 1'b0;
`endif

endmodule
